// File: rtl/enemy_pkg.sv
// ---------------------------------------------------------------------------
// enemy_pkg
// Shared definitions for the enemy game-logic layer: pixel field widths,
// the scheduler state encoding and the enemy movement action codes used by
// both the enemy instances and the collision detector.
// No ports (package).
// ---------------------------------------------------------------------------
package enemy_pkg;

   localparam int X_W      = 9;
   localparam int Y_W      = 8;
   localparam int COLOUR_W = 6;

   typedef enum logic [3:0] {
      S_WAIT    = 4'd0,
      S_INIT    = 4'd1,
      S_IDLE    = 4'd2,
      S_GEN     = 4'd3,
      S_APPLY   = 4'd4,
      S_SCAN    = 4'd5,
      S_DRAW    = 4'd6,
      S_RELEASE = 4'd7,
      S_DONE    = 4'd8
   } sched_state_t;

   typedef enum logic [2:0] {
      NO_ACTION = 3'd0,
      UP        = 3'd1,
      DOWN      = 3'd2,
      LEFT      = 3'd3,
      RIGHT     = 3'd4
   } enemy_action_t;

endpackage

// File: rtl/enemy_scheduler_if.sv
// ---------------------------------------------------------------------------
// enemy_scheduler_if
// Bundle between the scheduler and the NUM_ENEMIES enemy instances.
//   enemy -> scheduler : enemy_alive, draw_done_in, x_draw_in, y_draw_in,
//                        colour_in, vga_write_in (packed, enemy i in slice i)
//   scheduler -> enemy : init, idle, gen_move, apply_move, draw_en
// modport master : scheduler side
// modport slave  : enemy side
// ---------------------------------------------------------------------------
interface enemy_scheduler_if
   import enemy_pkg::*;
#(
   parameter int NUM_ENEMIES = 4
) ();

   logic [NUM_ENEMIES-1:0]          enemy_alive;
   logic [NUM_ENEMIES-1:0]          draw_done_in;
   logic [X_W*NUM_ENEMIES-1:0]      x_draw_in;
   logic [Y_W*NUM_ENEMIES-1:0]      y_draw_in;
   logic [COLOUR_W*NUM_ENEMIES-1:0] colour_in;
   logic [NUM_ENEMIES-1:0]          vga_write_in;

   logic                            init;
   logic                            idle;
   logic                            gen_move;
   logic                            apply_move;
   logic [NUM_ENEMIES-1:0]          draw_en;

   modport master (
      input  enemy_alive, draw_done_in, x_draw_in, y_draw_in, colour_in, vga_write_in,
      output init, idle, gen_move, apply_move, draw_en
   );

   modport slave (
      output enemy_alive, draw_done_in, x_draw_in, y_draw_in, colour_in, vga_write_in,
      input  init, idle, gen_move, apply_move, draw_en
   );

endinterface

// File: rtl/enemy_pixel_mux.sv
// ---------------------------------------------------------------------------
// enemy_pixel_mux
// Selects one enemy's pixel stream out of the packed per-enemy buses.
//   i_sel        : enemy index; values >= NUM_ENEMIES select all zeros
//   i_xBus       : packed x, enemy i in [X_W*i +: X_W]
//   i_yBus       : packed y
//   i_colourBus  : packed colour
//   i_writeBus   : per-enemy write enable
//   o_x/o_y/o_colour/o_write : selected enemy's pixel
// ---------------------------------------------------------------------------
module enemy_pixel_mux
   import enemy_pkg::*;
#(
   parameter int NUM_ENEMIES = 4,
   parameter int IDX_W       = 3
) (
   input  logic [IDX_W-1:0]                i_sel,
   input  logic [X_W*NUM_ENEMIES-1:0]      i_xBus,
   input  logic [Y_W*NUM_ENEMIES-1:0]      i_yBus,
   input  logic [COLOUR_W*NUM_ENEMIES-1:0] i_colourBus,
   input  logic [NUM_ENEMIES-1:0]          i_writeBus,
   output logic [X_W-1:0]                  o_x,
   output logic [Y_W-1:0]                  o_y,
   output logic [COLOUR_W-1:0]             o_colour,
   output logic                            o_write
);

   // Priority-free select: at most one index matches, and an index past the
   // last enemy leaves every output at its zero default.
   always_comb begin
      o_x      = '0;
      o_y      = '0;
      o_colour = '0;
      o_write  = 1'b0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
         if (i_sel == IDX_W'(i)) begin
            o_x      = i_xBus[X_W*i +: X_W];
            o_y      = i_yBus[Y_W*i +: Y_W];
            o_colour = i_colourBus[COLOUR_W*i +: COLOUR_W];
            o_write  = i_writeBus[i];
         end
      end
   end

endmodule

// File: rtl/enemy_scheduler.sv
// ---------------------------------------------------------------------------
// enemy_scheduler
// Central sequencer for the enemy instances. Each accepted frame_tick gives
// one gen_move pulse, one apply_move pulse, then grants the VGA path to each
// alive enemy in index order (draw_en one-hot until its draw_done, then one
// release cycle) and reports frame_done. Ticks that cannot be accepted are
// dropped and flagged with frame_overrun.
// Ports:
//   clock, resetn (async, active-low)
//   game_start, frame_tick          : control pulses from the game FSM
//   bus (enemy_scheduler_if.master) : per-enemy strobes and pixel buses
//   x_out, y_out, colour_out, vga_write_out : pixel stream to the VGA adapter
//   busy, frame_done, frame_overrun : status to the game FSM
//   draw_timeout_err                : sticky watchdog flag (optional)
// Optional feature macro: ENEMY_SCHED_DRAW_TIMEOUT_EN adds a per-grant draw
// watchdog of DRAW_TIMEOUT cycles and the draw_timeout_err port.
// ---------------------------------------------------------------------------
module enemy_scheduler
   import enemy_pkg::*;
#(
   parameter int NUM_ENEMIES  = 4,
   parameter int IDX_W        = 3,
   parameter int DRAW_TIMEOUT = 300
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                game_start,
   input  logic                frame_tick,
   enemy_scheduler_if.master   bus,
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                vga_write_out,
   output logic                busy,
   output logic                frame_done,
   output logic                frame_overrun
`ifdef ENEMY_SCHED_DRAW_TIMEOUT_EN
   ,
   output logic                draw_timeout_err
`endif
);

   // The index must be able to hold NUM_ENEMIES itself (the end-of-scan
   // marker), and the watchdog counter is only 9 bits wide.
   if ((1 << IDX_W) <= NUM_ENEMIES || NUM_ENEMIES < 1 || NUM_ENEMIES > 8 ||
       DRAW_TIMEOUT < 1 || DRAW_TIMEOUT > 512) begin : g_badParams
      $error("enemy_scheduler: illegal parameter combination");
   end

   localparam logic [IDX_W-1:0] LAST_SEL = IDX_W'(NUM_ENEMIES);

   sched_state_t           r_state;
   sched_state_t           w_nextState;
   logic [IDX_W-1:0]       r_sel;
   logic [IDX_W-1:0]       w_nextSel;
   logic [NUM_ENEMIES-1:0] r_aliveQ;
   logic [NUM_ENEMIES-1:0] w_aliveShift;
   logic [NUM_ENEMIES-1:0] w_doneShift;
   logic [NUM_ENEMIES-1:0] w_selOneHot;
   logic                   w_overrun;
   logic                   w_wdogExpired;
   logic                   w_muxWrite;

   logic                   r_init;
   logic                   r_idle;
   logic                   r_gen;
   logic                   r_apply;
   logic [NUM_ENEMIES-1:0] r_drawEn;
   logic                   r_busy;
   logic                   r_frameDone;
   logic                   r_overrun;

   assign w_aliveShift = r_aliveQ >> r_sel;
   assign w_doneShift  = bus.draw_done_in >> r_sel;

`ifdef ENEMY_SCHED_DRAW_TIMEOUT_EN
   logic [8:0] r_wdog;
   logic       r_timeoutErr;

   assign w_wdogExpired    = (r_state == S_DRAW) && (r_wdog == 9'(DRAW_TIMEOUT - 1));
   assign draw_timeout_err = r_timeoutErr;

   // Watchdog restarts on every new grant so each enemy gets the full
   // budget; the error flag is sticky until the game restarts.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wdog       <= '0;
         r_timeoutErr <= 1'b0;
      end else begin
         if (w_nextState == S_DRAW && r_state != S_DRAW) begin
            r_wdog <= '0;
         end else if (r_state == S_DRAW) begin
            r_wdog <= r_wdog + 9'd1;
         end
         if (game_start) begin
            r_timeoutErr <= 1'b0;
         end else if (w_wdogExpired && !w_doneShift[0]) begin
            r_timeoutErr <= 1'b1;
         end
      end
   end
`else
   assign w_wdogExpired = 1'b0;
`endif

   // Next-state and next-index logic. game_start overrides everything,
   // including a simultaneous frame_tick, which is then reported as dropped.
   always_comb begin
      w_nextState = r_state;
      w_nextSel   = r_sel;
      w_overrun   = 1'b0;
      if (game_start) begin
         w_nextState = S_INIT;
         w_nextSel   = '0;
         w_overrun   = frame_tick;
      end else begin
         w_overrun = frame_tick && (r_state != S_IDLE);
         case (r_state)
            S_WAIT:    w_nextState = S_WAIT;
            S_INIT:    w_nextState = S_IDLE;
            S_IDLE: begin
               if (frame_tick) begin
                  w_nextState = S_GEN;
                  w_nextSel   = '0;
               end
            end
            S_GEN:     w_nextState = S_APPLY;
            S_APPLY:   w_nextState = S_SCAN;
            S_SCAN: begin
               if (r_sel == LAST_SEL) begin
                  w_nextState = S_DONE;
               end else if (w_aliveShift[0]) begin
                  w_nextState = S_DRAW;
               end else begin
                  w_nextSel = r_sel + 1'b1;
               end
            end
            S_DRAW: begin
               if (w_doneShift[0] || w_wdogExpired) begin
                  w_nextState = S_RELEASE;
               end
            end
            S_RELEASE: begin
               w_nextState = S_SCAN;
               w_nextSel   = r_sel + 1'b1;
            end
            S_DONE:    w_nextState = S_IDLE;
            default:   w_nextState = S_WAIT;
         endcase
      end
   end

   // One-hot grant decoded from the index the FSM is about to hold.
   always_comb begin
      w_selOneHot = '0;
      for (int i = 0; i < NUM_ENEMIES; i++) begin
         w_selOneHot[i] = (w_nextSel == IDX_W'(i));
      end
   end

   // State, index and the alive snapshot. The snapshot is taken only when a
   // frame is accepted, so alive changes during a frame have no effect.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_WAIT;
         r_sel    <= '0;
         r_aliveQ <= '0;
      end else begin
         r_state <= w_nextState;
         r_sel   <= w_nextSel;
         if (r_state == S_IDLE && frame_tick && !game_start) begin
            r_aliveQ <= bus.enemy_alive;
         end
      end
   end

   // Registered outputs decoded from the next state, so every strobe lines
   // up with the cycle its state is occupied.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_init      <= 1'b0;
         r_idle      <= 1'b0;
         r_gen       <= 1'b0;
         r_apply     <= 1'b0;
         r_drawEn    <= '0;
         r_busy      <= 1'b0;
         r_frameDone <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_init      <= (w_nextState == S_INIT);
         r_idle      <= (w_nextState == S_IDLE);
         r_gen       <= (w_nextState == S_GEN);
         r_apply     <= (w_nextState == S_APPLY);
         r_drawEn    <= (w_nextState == S_DRAW) ? w_selOneHot : '0;
         r_busy      <= (w_nextState inside {S_GEN, S_APPLY, S_SCAN, S_DRAW, S_RELEASE});
         r_frameDone <= (w_nextState == S_DONE);
         r_overrun   <= w_overrun;
      end
   end

   assign bus.init       = r_init;
   assign bus.idle       = r_idle;
   assign bus.gen_move   = r_gen;
   assign bus.apply_move = r_apply;
   assign bus.draw_en    = r_drawEn;
   assign busy           = r_busy;
   assign frame_done     = r_frameDone;
   assign frame_overrun  = r_overrun;

   enemy_pixel_mux #(
      .NUM_ENEMIES (NUM_ENEMIES),
      .IDX_W       (IDX_W)
   ) u_pixelMux (
      .i_sel       (r_sel),
      .i_xBus      (bus.x_draw_in),
      .i_yBus      (bus.y_draw_in),
      .i_colourBus (bus.colour_in),
      .i_writeBus  (bus.vga_write_in),
      .o_x         (x_out),
      .o_y         (y_out),
      .o_colour    (colour_out),
      .o_write     (w_muxWrite)
   );

   // Only the enemy currently holding the grant may write to the VGA path.
   assign vga_write_out = w_muxWrite && (r_state == S_DRAW);

endmodule

// File: tb/tb_enemy_scheduler.sv
// ---------------------------------------------------------------------------
// tb_enemy_scheduler
// Self-checking bench for enemy_scheduler with four modelled enemies that
// raise draw_done on the 257th cycle of their grant.
// ---------------------------------------------------------------------------
module tb_enemy_scheduler;
   import enemy_pkg::*;

   localparam int N     = 4;
   localparam int LIMIT = 3000;

   logic clock = 1'b0;
   logic resetn;
   logic game_start;
   logic frame_tick;
   logic [X_W-1:0]      x_out;
   logic [Y_W-1:0]      y_out;
   logic [COLOUR_W-1:0] colour_out;
   logic vga_write_out;
   logic busy;
   logic frame_done;
   logic frame_overrun;
`ifdef ENEMY_SCHED_DRAW_TIMEOUT_EN
   logic timeoutErr;
`endif

   enemy_scheduler_if #(.NUM_ENEMIES(N)) enemyBus ();

   enemy_scheduler #(
      .NUM_ENEMIES  (N),
      .IDX_W        (3),
      .DRAW_TIMEOUT (300)
   ) dut (
      .clock         (clock),
      .resetn        (resetn),
      .game_start    (game_start),
      .frame_tick    (frame_tick),
      .bus           (enemyBus),
      .x_out         (x_out),
      .y_out         (y_out),
      .colour_out    (colour_out),
      .vga_write_out (vga_write_out),
      .busy          (busy),
      .frame_done    (frame_done),
      .frame_overrun (frame_overrun)
`ifdef ENEMY_SCHED_DRAW_TIMEOUT_EN
      ,
      .draw_timeout_err (timeoutErr)
`endif
   );

   always #5 clock = ~clock;

   // Enemy-side stimulus: fixed pixel values per enemy, alive mask, a
   // draw_done noise mask for enemies that should never be listened to, and
   // a stuck mask for enemies that never finish drawing.
   logic [N-1:0]            aliveIn;
   logic [N-1:0]            noise;
   logic [N-1:0]            stuck;
   logic [N-1:0]            vgaIn;
   logic [N-1:0]            modelDone;
   logic [X_W*N-1:0]        xBus;
   logic [Y_W*N-1:0]        yBus;
   logic [COLOUR_W*N-1:0]   colourBus;
   int                      drawCnt [N];

   function automatic logic [X_W-1:0] xOf(int i);
      return X_W'(37 * i + 101);
   endfunction
   function automatic logic [Y_W-1:0] yOf(int i);
      return Y_W'(23 * i + 11);
   endfunction
   function automatic logic [COLOUR_W-1:0] colOf(int i);
      return COLOUR_W'(9 * i + 5);
   endfunction

   always_comb begin
      xBus      = '0;
      yBus      = '0;
      colourBus = '0;
      for (int i = 0; i < N; i++) begin
         xBus[X_W*i +: X_W]                = xOf(i);
         yBus[Y_W*i +: Y_W]                = yOf(i);
         colourBus[COLOUR_W*i +: COLOUR_W] = colOf(i);
      end
   end

   // Enemy draw model: done on the 257th cycle of its own grant.
   always @(posedge clock) begin
      for (int i = 0; i < N; i++) begin
         drawCnt[i] <= enemyBus.draw_en[i] ? drawCnt[i] + 1 : 0;
      end
   end

   always_comb begin
      modelDone = '0;
      for (int i = 0; i < N; i++) begin
         modelDone[i] = enemyBus.draw_en[i] && (drawCnt[i] == 256) && !stuck[i];
      end
   end

   assign enemyBus.enemy_alive  = aliveIn;
   assign enemyBus.draw_done_in = modelDone | noise;
   assign enemyBus.x_draw_in    = xBus;
   assign enemyBus.y_draw_in    = yBus;
   assign enemyBus.colour_in    = colourBus;
   assign enemyBus.vga_write_in = vgaIn;

   // Frame monitor, sampled mid-cycle.
   int genCnt, applyCnt, initCnt, doneCnt, ovrCnt, busyCnt;
   int drawStarts, firstIdx, lastIdx, orderBad, oneHotBad, pixBad;
   int monIdx;
   logic [N-1:0] drawUnion;
   logic [N-1:0] prevDrawEn;

   always @(negedge clock) begin
      if (enemyBus.gen_move)   genCnt++;
      if (enemyBus.apply_move) applyCnt++;
      if (enemyBus.init)       initCnt++;
      if (frame_done)          doneCnt++;
      if (frame_overrun)       ovrCnt++;
      if (busy)                busyCnt++;
      if (enemyBus.draw_en != '0) begin
         monIdx = 0;
         for (int i = 0; i < N; i++) if (enemyBus.draw_en[i]) monIdx = i;
         if ($countones(enemyBus.draw_en) != 1) begin
            oneHotBad++;
         end else if (x_out != xOf(monIdx) || y_out != yOf(monIdx) ||
                      colour_out != colOf(monIdx) || vga_write_out != vgaIn[monIdx]) begin
            pixBad++;
         end
         if (prevDrawEn == '0) begin
            if (drawStarts > 0 && monIdx <= lastIdx) orderBad++;
            if (drawStarts == 0) firstIdx = monIdx;
            lastIdx = monIdx;
            drawStarts++;
         end
         drawUnion = drawUnion | enemyBus.draw_en;
      end else if (vga_write_out) begin
         pixBad++;
      end
      prevDrawEn = enemyBus.draw_en;
   end

   int compared   = 0;
   int mismatched = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic clearCounters();
      genCnt = 0; applyCnt = 0; initCnt = 0; doneCnt = 0; ovrCnt = 0; busyCnt = 0;
      drawStarts = 0; firstIdx = -1; lastIdx = -1;
      orderBad = 0; oneHotBad = 0; pixBad = 0;
      drawUnion = '0; prevDrawEn = '0;
   endtask

   task automatic pulseGameStart();
      @(posedge clock); #1;
      game_start = 1'b1;
      @(posedge clock); #1;
      game_start = 1'b0;
   endtask

   // Runs one frame from an accepted tick to frame_done. Cycle 1 is the
   // gen_move cycle; alive is changed at cycle 50 and an extra tick can be
   // injected at cycle extraAt.
   task automatic applyStimulus(input logic [N-1:0] alive, input logic [N-1:0] aliveMid,
                                input logic [N-1:0] noiseMask, input int extraAt,
                                output int cycles);
      @(posedge clock); #1;
      clearCounters();
      aliveIn    = alive;
      noise      = noiseMask;
      frame_tick = 1'b1;
      @(posedge clock); #1;
      frame_tick = 1'b0;
      cycles = 1;
      while (!frame_done && cycles < LIMIT) begin
         @(posedge clock); #1;
         cycles++;
         frame_tick = (extraAt != 0 && cycles == extraAt);
         if (cycles == 50) aliveIn = aliveMid;
      end
      frame_tick = 1'b0;
      checkOutput("frameDoneSeen", int'(frame_done), 1);
      @(negedge clock); #1;
      noise = '0;
   endtask

   typedef struct {
      logic [N-1:0] alive;
      logic [N-1:0] aliveMid;
      logic [N-1:0] noise;
      int           expCycles;
      logic [N-1:0] expUnion;
      int           expDraws;
      int           expFirst;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int cyc;
      int w;

      vecs[0] = '{4'b1111, 4'b1111, 4'b0000, 1040, 4'b1111, 4,  0};
      vecs[1] = '{4'b0101, 4'b1111, 4'b1010,  524, 4'b0101, 2,  0};
      vecs[2] = '{4'b0000, 4'b1111, 4'b0000,    8, 4'b0000, 0, -1};
      vecs[3] = '{4'b1000, 4'b0000, 4'b0111,  266, 4'b1000, 1,  3};
      vecs[4] = '{4'b0110, 4'b0000, 4'b0000,  524, 4'b0110, 2,  1};

      resetn     = 1'b0;
      game_start = 1'b0;
      frame_tick = 1'b0;
      aliveIn    = '0;
      noise      = '0;
      stuck      = '0;
      vgaIn      = 4'b1011;
      clearCounters();

      // Reset state
      #1;
      checkOutput("rstDrawEn", int'(enemyBus.draw_en), 0);
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstIdle", int'(enemyBus.idle), 0);
      checkOutput("rstInit", int'(enemyBus.init), 0);
      checkOutput("rstDone", int'(frame_done), 0);
      checkOutput("rstVgaWrite", int'(vga_write_out), 0);
      repeat (3) @(negedge clock);
      resetn = 1'b1;

      // Tick in S_WAIT: only an overrun
      @(posedge clock); #1;
      frame_tick = 1'b1;
      @(posedge clock); #1;
      frame_tick = 1'b0;
      checkOutput("waitTickOverrun", int'(frame_overrun), 1);
      checkOutput("waitTickNoGen", int'(enemyBus.gen_move), 0);
      checkOutput("waitTickIdle", int'(enemyBus.idle), 0);

      // game_start: one-cycle init then idle
      pulseGameStart();
      checkOutput("initPulse", int'(enemyBus.init), 1);
      checkOutput("initNotIdle", int'(enemyBus.idle), 0);
      @(posedge clock); #1;
      checkOutput("initCleared", int'(enemyBus.init), 0);
      checkOutput("idleAfterInit", int'(enemyBus.idle), 1);

      // Table-driven frames
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].alive, vecs[v].aliveMid, vecs[v].noise, 0, cyc);
         checkOutput($sformatf("v%0d.cycles", v), cyc, vecs[v].expCycles);
         checkOutput($sformatf("v%0d.union", v), int'(drawUnion), int'(vecs[v].expUnion));
         checkOutput($sformatf("v%0d.draws", v), drawStarts, vecs[v].expDraws);
         checkOutput($sformatf("v%0d.first", v), firstIdx, vecs[v].expFirst);
         checkOutput($sformatf("v%0d.gen", v), genCnt, 1);
         checkOutput($sformatf("v%0d.apply", v), applyCnt, 1);
         checkOutput($sformatf("v%0d.done", v), doneCnt, 1);
         checkOutput($sformatf("v%0d.busyCycles", v), busyCnt, vecs[v].expCycles - 1);
         checkOutput($sformatf("v%0d.overrun", v), ovrCnt, 0);
         checkOutput($sformatf("v%0d.order", v), orderBad, 0);
         checkOutput($sformatf("v%0d.oneHot", v), oneHotBad, 0);
         checkOutput($sformatf("v%0d.pixel", v), pixBad, 0);
      end

      // Extra tick at cycle 100 of a frame is dropped
      applyStimulus(4'b1111, 4'b1111, 4'b0000, 100, cyc);
      checkOutput("ovr.cycles", cyc, 1040);
      checkOutput("ovr.overrun", ovrCnt, 1);
      checkOutput("ovr.gen", genCnt, 1);
      checkOutput("ovr.done", doneCnt, 1);

      // game_start while enemy 2 is drawing aborts the frame
      @(posedge clock); #1;
      clearCounters();
      aliveIn    = 4'b1111;
      frame_tick = 1'b1;
      @(posedge clock); #1;
      frame_tick = 1'b0;
      w = 0;
      while (enemyBus.draw_en != 4'b0100 && w < LIMIT) begin
         @(posedge clock); #1;
         w++;
      end
      checkOutput("abortReached", int'(enemyBus.draw_en), 4);
      game_start = 1'b1;
      @(posedge clock); #1;
      game_start = 1'b0;
      checkOutput("abortDrawEn", int'(enemyBus.draw_en), 0);
      checkOutput("abortInit", int'(enemyBus.init), 1);
      checkOutput("abortBusy", int'(busy), 0);
      repeat (5) @(posedge clock);
      #1;
      checkOutput("abortIdle", int'(enemyBus.idle), 1);
      @(negedge clock); #1;
      checkOutput("abortNoDone", doneCnt, 0);
      applyStimulus(4'b1111, 4'b1111, 4'b0000, 0, cyc);
      checkOutput("afterAbort.first", firstIdx, 0);
      checkOutput("afterAbort.cycles", cyc, 1040);

      // game_start and frame_tick together: restart wins, tick overruns
      @(posedge clock); #1;
      clearCounters();
      game_start = 1'b1;
      frame_tick = 1'b1;
      @(posedge clock); #1;
      game_start = 1'b0;
      frame_tick = 1'b0;
      checkOutput("bothInit", int'(enemyBus.init), 1);
      checkOutput("bothOverrun", int'(frame_overrun), 1);
      @(posedge clock); #1;
      checkOutput("bothIdle", int'(enemyBus.idle), 1);
      @(negedge clock); #1;
      checkOutput("bothNoGen", genCnt, 0);

      // Asynchronous reset in the middle of a draw
      @(posedge clock); #1;
      aliveIn    = 4'b1111;
      frame_tick = 1'b1;
      @(posedge clock); #1;
      frame_tick = 1'b0;
      w = 0;
      while (enemyBus.draw_en == '0 && w < LIMIT) begin
         @(posedge clock); #1;
         w++;
      end
      checkOutput("arstReachedDraw", int'(enemyBus.draw_en), 1);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("arstDrawEn", int'(enemyBus.draw_en), 0);
      checkOutput("arstBusy", int'(busy), 0);
      checkOutput("arstVgaWrite", int'(vga_write_out), 0);
      @(negedge clock);
      resetn = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("arstIdle", int'(enemyBus.idle), 0);
      checkOutput("arstInit", int'(enemyBus.init), 0);
      checkOutput("arstStillBusy", int'(busy), 0);
      pulseGameStart();
      @(posedge clock); #1;

`ifdef ENEMY_SCHED_DRAW_TIMEOUT_EN
      // Enemy 1 never finishes: watchdog releases it after 300 cycles
      stuck = 4'b0010;
      applyStimulus(4'b1111, 4'b1111, 4'b0000, 0, cyc);
      stuck = '0;
      checkOutput("wdog.cycles", cyc, 1083);
      checkOutput("wdog.union", int'(drawUnion), 15);
      checkOutput("wdog.draws", drawStarts, 4);
      checkOutput("wdog.err", int'(timeoutErr), 1);
      pulseGameStart();
      checkOutput("wdog.errCleared", int'(timeoutErr), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
